// File: rtl/pong_pkg.sv
// Shared types and constants for the pong round sequencer.
package pong_pkg;

    localparam int X_W = 10;
    localparam int Y_W = 9;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_POINT = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } ball_pos_t;

    function automatic logic is_point(input logic [1:0] w);
        return (w == WIN_P1) || (w == WIN_P2);
    endfunction

endpackage

// File: rtl/round_timer.sv
// Up-counter with clear and increment-enable; done_o flags the increment that
// completes LIMIT counts, at which point the counter wraps back to zero.
module round_timer #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic done_o
);
    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] count_q, count_d;

    always_comb begin
        done_o  = inc_i && (count_q == W'(LIMIT - 1));
        count_d = count_q;
        if (clr_i || done_o) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/game_round_ctrl.sv
// Game sequencer: serve/play/point/over, score keeping, CPU reset and enable,
// and a per-frame latch of the ball position for the display.
// state | meaning
// IDLE  | waiting for start, CPU in reset
// SERVE | CPU held in reset for SERVE_CYCLES before a rally
// PLAY  | CPU running, watching winner code
// POINT | freeze for POINT_FRAMES frames after a point
// OVER  | target score reached, waiting for restart
module game_round_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned SERVE_CYCLES = 50000000,
    parameter int unsigned POINT_FRAMES = 60,
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SCORE_W      = 4
) (
    input  logic               clock_i,
    input  logic               reset_ni,
    input  logic               start_i,
    input  logic               pause_i,
    input  logic               frame_tick_i,
    input  logic [1:0]         winner_i,
    input  logic [X_W-1:0]     ball_x_i,
    input  logic [Y_W-1:0]     ball_y_i,
    output logic               cpu_reset_o,
    output logic               cpu_en_o,
    output logic [X_W-1:0]     ball_x_disp_o,
    output logic [Y_W-1:0]     ball_y_disp_o,
    output logic [SCORE_W-1:0] score_p1_o,
    output logic [SCORE_W-1:0] score_p2_o,
    output logic [1:0]         last_winner_o,
    output logic               game_over_o,
    output logic [2:0]         state_dbg_o
);
    localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

    logic [2:0]         state_q, state_d;
    logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic [1:0]         lw_q, lw_d;
    ball_pos_t          disp_q;
    logic               cpu_reset_q, cpu_en_q, game_over_q;
    logic               serve_clr, serve_done, point_clr, point_done;

    round_timer #(.LIMIT(SERVE_CYCLES)) u_serve_timer (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .clr_i    (serve_clr),
        .inc_i    (state_q == ST_SERVE),
        .done_o   (serve_done)
    );

    round_timer #(.LIMIT(POINT_FRAMES)) u_point_timer (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .clr_i    (point_clr),
        .inc_i    ((state_q == ST_POINT) && frame_tick_i),
        .done_o   (point_done)
    );

    always_comb begin
        state_d   = state_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        lw_d      = lw_q;
        serve_clr = 1'b0;
        point_clr = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_i) begin
                    state_d   = ST_SERVE;
                    p1_d      = '0;
                    p2_d      = '0;
                    lw_d      = WIN_NONE;
                    serve_clr = 1'b1;
                end
            end
            ST_SERVE: begin
                if (serve_done) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // Scoring only here, so a winner code left set by the regfile cannot recount.
                if (is_point(winner_i)) begin
                    lw_d = winner_i;
                    if (winner_i == WIN_P1) p1_d = p1_q + SCORE_W'(1);
                    else                    p2_d = p2_q + SCORE_W'(1);
                    if ((p1_d == WIN_S) || (p2_d == WIN_S)) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d   = ST_POINT;
                        point_clr = 1'b1;
                    end
                end
            end
            ST_POINT: begin
                if (point_done) begin
                    state_d   = ST_SERVE;
                    serve_clr = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            p1_q        <= '0;
            p2_q        <= '0;
            lw_q        <= WIN_NONE;
            disp_q      <= '0;
            cpu_reset_q <= 1'b1;
            cpu_en_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            lw_q        <= lw_d;
            cpu_reset_q <= (state_d != ST_PLAY);
            cpu_en_q    <= (state_d == ST_PLAY) && !pause_i;
            game_over_q <= (state_d == ST_OVER);
            if ((state_q == ST_PLAY) && frame_tick_i) begin
                disp_q <= '{x: ball_x_i, y: ball_y_i};
            end
        end
    end

    assign cpu_reset_o   = cpu_reset_q;
    assign cpu_en_o      = cpu_en_q;
    assign ball_x_disp_o = disp_q.x;
    assign ball_y_disp_o = disp_q.y;
    assign score_p1_o    = p1_q;
    assign score_p2_o    = p2_q;
    assign last_winner_o = lw_q;
    assign game_over_o   = game_over_q;
    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: directed game scenarios then random play, every
// cycle compared against a behavioural game model.
module tb_game_round_ctrl;

    localparam int SERVE_N = 4;
    localparam int POINT_N = 2;
    localparam int WIN_N   = 3;

    logic       clock, reset_n, start, pause, frame_tick;
    logic [1:0] winner;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       cpu_reset, cpu_en, game_over;
    logic [9:0] ball_x_disp;
    logic [8:0] ball_y_disp;
    logic [3:0] score_p1, score_p2;
    logic [1:0] last_winner;
    logic [2:0] state_dbg;

    game_round_ctrl #(
        .SERVE_CYCLES(SERVE_N), .POINT_FRAMES(POINT_N), .WIN_SCORE(WIN_N), .SCORE_W(4)
    ) dut (
        .clock_i(clock), .reset_ni(reset_n), .start_i(start), .pause_i(pause),
        .frame_tick_i(frame_tick), .winner_i(winner), .ball_x_i(ball_x), .ball_y_i(ball_y),
        .cpu_reset_o(cpu_reset), .cpu_en_o(cpu_en), .ball_x_disp_o(ball_x_disp),
        .ball_y_disp_o(ball_y_disp), .score_p1_o(score_p1), .score_p2_o(score_p2),
        .last_winner_o(last_winner), .game_over_o(game_over), .state_dbg_o(state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;

    // Game model: phase uses the published state_dbg numbering; timers count what is left.
    int m_phase, m_serve_left, m_frames_left, m_p1, m_p2, m_lw, m_dx, m_dy;
    bit m_en;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_serve_left = 0; m_frames_left = 0;
        m_p1 = 0; m_p2 = 0; m_lw = 0; m_dx = 0; m_dy = 0; m_en = 0;
    endtask

    task automatic model_edge();
        case (m_phase)
            0, 4: if (start) begin
                m_phase = 1; m_serve_left = SERVE_N; m_p1 = 0; m_p2 = 0; m_lw = 0;
            end
            1: begin
                m_serve_left--;
                if (m_serve_left == 0) m_phase = 2;
            end
            2: begin
                if (frame_tick) begin m_dx = ball_x; m_dy = ball_y; end
                if (winner == 1 || winner == 2) begin
                    if (winner == 1) m_p1++; else m_p2++;
                    m_lw = winner;
                    if (m_p1 == WIN_N || m_p2 == WIN_N) m_phase = 4;
                    else begin m_phase = 3; m_frames_left = POINT_N; end
                end
            end
            3: if (frame_tick) begin
                m_frames_left--;
                if (m_frames_left == 0) begin m_phase = 1; m_serve_left = SERVE_N; end
            end
            default: ;
        endcase
        m_en = (m_phase == 2) && !pause;
    endtask

    task automatic compare_all();
        check_eq("state_dbg",   state_dbg,   m_phase);
        check_eq("cpu_reset",   cpu_reset,   m_phase != 2);
        check_eq("cpu_en",      cpu_en,      m_en);
        check_eq("score_p1",    score_p1,    m_p1);
        check_eq("score_p2",    score_p2,    m_p2);
        check_eq("last_winner", last_winner, m_lw);
        check_eq("game_over",   game_over,   m_phase == 4);
        check_eq("ball_x_disp", ball_x_disp, m_dx);
        check_eq("ball_y_disp", ball_y_disp, m_dy);
    endtask

    task automatic step();
        frame_tick = (cyc_cnt % 10 == 9);
        @(posedge clock);
        model_edge();
        cyc_cnt++;
        #1;
        compare_all();
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int n = 0;
        while (state_dbg != 3'(target) && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, state_dbg, target);
    endtask

    task automatic async_reset();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check_eq("arst_state", state_dbg, 0);
        check_eq("arst_cpu_reset", cpu_reset, 1);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int n;
        reset_n = 1'b0; start = 0; pause = 0; frame_tick = 0; winner = 0;
        ball_x = 0; ball_y = 0;
        model_reset();
        @(posedge clock);
        #1;
        compare_all();
        reset_n = 1'b1;

        // Serve length and first PLAY entry
        ball_x = 10'd321; ball_y = 9'd200;
        start = 1; step(); start = 0;
        n = 0;
        while (state_dbg == 3'd1 && n < 20) begin
            if (cpu_reset) n++;
            step();
        end
        check_eq("serve_len", n, SERVE_N);
        check_eq("play_en", cpu_en, 1);

        // Display latch, mid-frame changes
        repeat (3) step();
        ball_x = 10'd5; ball_y = 9'd6;
        repeat (3) step();
        ball_x = 10'd321; ball_y = 9'd200;
        repeat (12) step();

        // Held winner counts once
        winner = 2'd1;
        repeat (5) step();
        winner = 2'd0;
        check_eq("p1_once", score_p1, 1);
        ball_x = 10'd777; ball_y = 9'd400;
        run_until(2, 200, "back_to_play");
        check_eq("disp_hold_x", ball_x_disp, 321);
        check_eq("disp_hold_y", ball_y_disp, 200);

        // Invalid winner ignored, then P2 wins the game
        winner = 2'd3;
        repeat (15) step();
        check_eq("inv_p1", score_p1, 1);
        check_eq("inv_p2", score_p2, 0);
        winner = 2'd2;
        run_until(4, 400, "reach_over");
        winner = 2'd0;
        check_eq("p2_final", score_p2, WIN_N);
        check_eq("over_flag", game_over, 1);
        start = 1; step(); start = 0;
        check_eq("restart_p2", score_p2, 0);
        check_eq("restart_over", game_over, 0);

        // Pause gating and scoring during pause
        run_until(2, 100, "play_for_pause");
        pause = 1; step();
        check_eq("pause_en", cpu_en, 0);
        check_eq("pause_rst", cpu_reset, 0);
        winner = 2'd1; step(); winner = 2'd0;
        pause = 0;
        check_eq("pause_point", score_p1, 1);

        // Asynchronous reset in POINT, then a fresh serve
        run_until(3, 100, "reach_point");
        repeat (3) step();
        async_reset();
        start = 1; step(); start = 0;
        run_until(2, 100, "post_reset_play");

        // Random play
        for (int i = 0; i < 1500; i++) begin
            start  = ($urandom_range(0, 29) == 0);
            pause  = ($urandom_range(0, 5) == 0);
            winner = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            ball_x = 10'($urandom);
            ball_y = 9'($urandom);
            if ($urandom_range(0, 499) == 0) async_reset();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Sequences the pong processor across a full game: holds the CPU in reset between rallies and gates its clock enable.
- Watches the regfile-exported `winner` code, keeps both scores and ends the game at a target score.
- Latches `ball_x`/`ball_y` once per video frame so the display sees a tear-free position.
- Sits between the top-level wrapper (CPU + regfile) and the VGA/display logic.

Parameters:
- SERVE_CYCLES, 50000000, clock cycles the CPU is held in reset before each serve (1 s at 50 MHz).
- POINT_FRAMES, 60, frame_tick pulses of freeze after a point is scored.
- WIN_SCORE, 7, score that ends the game; must be ≥1 and < 2^SCORE_W.
- SCORE_W, 4, score counter width.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin or restart a game
- pause  in  1  level: freeze CPU during play
- frame_tick  in  1  one-cycle pulse per video frame (vsync)
- winner  in  2  regfile winner code: 0 none, 1 P1, 2 P2, 3 invalid
- ball_x  in  10  regfile ball x
- ball_y  in  9  regfile ball y
- cpu_reset  out  1  active-high reset to processor/regfile
- cpu_en  out  1  processor clock enable
- ball_x_disp  out  10  frame-latched ball x
- ball_y_disp  out  9  frame-latched ball y
- score_p1  out  SCORE_W  player 1 score
- score_p2  out  SCORE_W  player 2 score
- last_winner  out  2  winner of the most recent point
- game_over  out  1  high while the game is finished
- state_dbg  out  3  current state encoding

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cpu_reset=1, cpu_en=0.
  - Scores, ball_x_disp, ball_y_disp and last_winner all 0; game_over=0; both counters 0.
- All outputs are registered. State changes take effect on the cycle after the triggering input is sampled.
- IDLE:
  - cpu_reset=1, cpu_en=0.
  - start=1 → SERVE; clears scores, last_winner and the serve counter.
- SERVE:
  - cpu_reset=1, cpu_en=0; the serve counter increments every cycle.
  - When the counter reaches SERVE_CYCLES-1 → PLAY and the counter clears.
  - CPU reset is therefore asserted for exactly SERVE_CYCLES cycles in SERVE.
- PLAY:
  - cpu_reset=0, cpu_en=!pause, registered, so cpu_en lags pause by one cycle.
  - winner=1 or 2 sampled → increment the matching score, last_winner=winner, then:
    - new score == WIN_SCORE → OVER;
    - otherwise → POINT, frame counter cleared.
  - Scores are evaluated only in PLAY, so the regfile winner staying set across later cycles never double-counts.
  - winner=3 is ignored and play continues.
  - winner is honoured even while pause=1.
  - start is ignored.
- POINT:
  - cpu_reset=1, cpu_en=0; the frame counter increments on each frame_tick.
  - On the frame_tick that makes the count POINT_FRAMES → SERVE, serve counter cleared.
- OVER:
  - game_over=1, cpu_reset=1, cpu_en=0; scores held.
  - start → SERVE with scores cleared, last_winner=0, game_over=0.
- Start in SERVE/POINT: ignored.
- Display latch:
  - In PLAY only, on frame_tick, ball_x_disp/ball_y_disp take the same-cycle ball_x/ball_y.
  - In all other states they hold their value.
  - frame_tick and a winner in the same PLAY cycle: the latch captures and the score updates, both in that cycle.
- Scores:
  - Never exceed WIN_SCORE; increments in any state other than PLAY are impossible.
  - Widths are unsigned; no wrap is reachable given the parameter constraint.
- State encoding for state_dbg: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.

Decomposition:
- Shared package `pong_pkg`:
  - state enum: IDLE, SERVE, PLAY, POINT, OVER with the encoding above;
  - winner code constants WIN_NONE=0, WIN_P1=1, WIN_P2=2;
  - screen-width constants (10-bit x, 9-bit y).
- One natural sub-module, `round_timer`: a loadable terminal-count counter with an increment-enable (every cycle or on frame_tick), used twice for the serve and point timers.
- FSM, score registers and display latch stay in the top.

Test Plan:
Bench parameters SERVE_CYCLES=4, POINT_FRAMES=2, WIN_SCORE=3, frame_tick every 10 cycles.
1. Release reset, pulse start → cpu_reset high exactly 4 cycles in SERVE, then state_dbg=2, cpu_reset=0, cpu_en=1; all scores 0.
2. In PLAY, hold winner=1 for 5 cycles → score_p1=1 (not 5), last_winner=1, state POINT, cpu_reset=1. After the 2nd frame_tick → SERVE; 4 cycles later → PLAY.
3. Drive ball_x=321, ball_y=200 and change them mid-frame → ball_x_disp/ball_y_disp update only on frame_tick in PLAY. They hold 321/200 through POINT and SERVE.
4. P2 scores three points (winner=2) → score_p2=3, game_over=1, state OVER. winner=3 injected in PLAY earlier → no score change. start → scores 0, game_over=0, SERVE.
5. pause=1 in PLAY → cpu_en=0 one cycle later with cpu_reset still 0. pause=0 → cpu_en=1. A winner arriving during pause still scores.
6. Assert reset=0 asynchronously mid-POINT (between clock edges) → outputs return to reset values immediately: state IDLE, cpu_reset=1, scores 0. Pulse start → normal serve.
